// File: rtl/wb_repne_sequencer.sv
// Writeback-side REPNE CMPS controller: tracks the working ECX count, detects loop
// termination from the retiring compare uop and issues the final ECX writeback.
module wb_repne_sequencer #(
  parameter int unsigned ITER_W = 16,
  parameter int unsigned ZF_BIT = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_V,
  input  logic              WB_stall,
  input  logic              WB_d2_repne_wb,
  input  logic              WB_is_cmps_first_uop,
  input  logic              WB_is_cmps_second_uop,
  input  logic [31:0]       WB_RESULT_C,
  input  logic [31:0]       WB_FLAGS,
  input  logic [31:0]       WB_ecx,
  output logic [31:0]       saved_count,
  output logic              repne_active,
  output logic              wb_repne_terminate_all,
  output logic              wb_repne_suppress,
  output logic              wb_ld_ecx,
  output logic [31:0]       wb_ecx_value,
  output logic [ITER_W-1:0] iter_count,
  output logic              repne_err
);

  typedef enum logic [1:0] {StIdle, StLoop, StTerm} state_e;

  state_e              state_q, state_d;
  logic [31:0]         saved_q, saved_d;
  logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
  logic                err_q, err_d;
  logic                adv, non_repne, is_first, is_second, term;

  assign adv       = WB_V & ~WB_stall & WB_d2_repne_wb;
  assign non_repne = WB_V & ~WB_stall & ~WB_d2_repne_wb;
  // A uop flagged as both first and second is handled as a compare uop.
  assign is_second = WB_is_cmps_second_uop;
  assign is_first  = WB_is_cmps_first_uop & ~WB_is_cmps_second_uop;
  assign term      = (WB_RESULT_C == 32'd0) | WB_FLAGS[ZF_BIT];
  assign iter_inc  = (iter_q == {ITER_W{1'b1}}) ? iter_q : iter_q + 1'b1;

  always_comb begin
    state_d           = state_q;
    saved_d           = saved_q;
    iter_d            = iter_q;
    err_d             = err_q;
    wb_repne_suppress = 1'b0;
    wb_ld_ecx         = 1'b0;
    wb_ecx_value      = 32'd0;
    case (state_q)
      StIdle: begin
        if (adv) begin
          if (is_second) begin
            err_d = 1'b1;
          end else if (is_first) begin
            saved_d = WB_ecx;
            iter_d  = '0;
            if (WB_ecx == 32'd0) begin
              wb_repne_suppress = 1'b1;
              state_d           = StTerm;
            end else begin
              state_d = StLoop;
            end
          end
        end
      end
      StLoop: begin
        if (non_repne) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (adv && is_second) begin
          if (WB_is_cmps_first_uop) err_d = 1'b1;
          saved_d = WB_RESULT_C;
          iter_d  = iter_inc;
          if (term) begin
            wb_ld_ecx    = 1'b1;
            wb_ecx_value = WB_RESULT_C;
            state_d      = StTerm;
          end
        end
      end
      // Uops seen here are already being flushed.
      StTerm:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (RST) begin
      wb_repne_suppress = 1'b0;
      wb_ld_ecx         = 1'b0;
      wb_ecx_value      = 32'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      saved_q <= 32'd0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  assign saved_count            = saved_q;
  assign repne_active           = (state_q == StLoop);
  assign wb_repne_terminate_all = (state_q == StTerm) & ~RST;
  assign iter_count             = iter_q;
  assign repne_err              = err_q;

endmodule

// File: doc/wb_repne_sequencer.md
Name: wb_repne_sequencer

Overview:
- Writeback-side controller for REPNE CMPS; sits directly downstream of the execute stage.
- Tracks the architectural ECX working count across iterations and feeds it back to execute as saved_count.
- Decides loop termination from the retiring compare uop's decremented count and ZF, then pulses wb_repne_terminate_all to flush/bubble execute.
- Issues the final ECX writeback.

Parameters:
- ITER_W, 16, width of the saturating iteration counter (debug/perf).
- ZF_BIT, 6, bit position of ZF within WB_FLAGS.

Ports:
- CLK input 1 clock, rising edge.
- RST input 1 synchronous active-high reset.
- WB_V input 1 writeback uop valid.
- WB_stall input 1 writeback stalled; freezes all state.
- WB_d2_repne_wb input 1 uop carries REPNE prefix.
- WB_is_cmps_first_uop input 1 uop is CMPS first (load) uop.
- WB_is_cmps_second_uop input 1 uop is CMPS second (compare) uop.
- WB_RESULT_C input 32 decremented count from execute (count-1).
- WB_FLAGS input 32 flags produced by the compare uop.
- WB_ecx input 32 architectural ECX read at loop entry.
- saved_count output 32 working count fed back to execute.
- repne_active output 1 execute uses saved_count instead of EX_C.
- wb_repne_terminate_all output 1 one-cycle terminate/flush pulse.
- wb_repne_suppress output 1 suppress GPR/dcache writes of the current uop (zero-count entry).
- wb_ld_ecx output 1 write wb_ecx_value to ECX this cycle.
- wb_ecx_value output 32 final ECX value.
- iter_count output ITER_W iterations completed, saturating.
- repne_err output 1 sticky protocol error.

Behaviour:
- Advance condition: adv = WB_V & ~WB_stall & WB_d2_repne_wb. With WB_stall=1, no register changes, but combinational outputs still reflect current state.
- States: IDLE, LOOP, TERM.
- Reset: state=IDLE, saved_count=0, iter_count=0, repne_err=0. All pulse outputs are 0 during the reset cycle.

IDLE:
- adv & first_uop & WB_ecx==0: wb_repne_suppress=1 (combinational, same cycle), then go to TERM. wb_ecx_value=0 and no ECX change is required, so wb_ld_ecx=0.
- adv & first_uop & WB_ecx!=0: saved_count<=WB_ecx, go to LOOP.
- adv & second_uop while in IDLE: repne_err<=1, state unchanged.

LOOP:
- repne_active=1.
- adv & second_uop, with term = (WB_RESULT_C==0) | WB_FLAGS[ZF_BIT]:
  - term=1: saved_count<=WB_RESULT_C, wb_ld_ecx=1 with wb_ecx_value=WB_RESULT_C (same cycle, combinational), iter_count+1, go to TERM.
  - term=0: saved_count<=WB_RESULT_C, iter_count+1, stay in LOOP.
- adv & first_uop: no state change; saved_count holds.
- Valid uop without REPNE while in LOOP: repne_err<=1, go to IDLE.

TERM:
- wb_repne_terminate_all=1 for exactly one cycle; go to IDLE unconditionally, even if WB_stall=1.
- iter_count clears on the next IDLE first_uop entry.
- Inputs arriving during TERM are ignored, since they are flushed uops.

Arithmetic and priority:
- iter_count saturates at all-ones and never wraps.
- Count wrap is not computed here; execute supplies the decrement.
- Simultaneous ZF=1 and count==0 gives a single termination. wb_ecx_value=0 in that case.
- Both first_uop and second_uop set in one cycle: treat as second_uop and set repne_err.
- RST asserted mid-loop: IDLE next cycle, no terminate pulse, no ECX write.
- All outputs other than the combinational strobes (wb_repne_suppress, wb_ld_ecx, wb_ecx_value) come from registers or state decode.

Test Plan:
- Entry with WB_ecx=3, ZF always 0, second uops returning 2,1,0:
  - saved_count reads 3 → 2 → 1.
  - On the 0 retire: wb_ld_ecx=1 with wb_ecx_value=0.
  - Next cycle: terminate pulse, iter_count=3, then back in IDLE.
- Entry with WB_ecx=5, ZF=1 on the second iteration with WB_RESULT_C=3:
  - wb_ld_ecx=1 with wb_ecx_value=3.
  - One terminate pulse follows; iter_count=2.
- Entry with WB_ecx=0:
  - wb_repne_suppress=1 in the entry cycle.
  - Terminate pulse next cycle; saved_count stays 0; wb_ld_ecx stays 0.
- WB_stall held 4 cycles mid-LOOP with a second uop present:
  - saved_count and iter_count unchanged during the stall.
  - They update once, in the cycle the stall drops.
- RST asserted in LOOP with saved_count=7:
  - Next cycle: IDLE, saved_count=0, no terminate pulse, repne_active=0.
- Second uop while in IDLE, then a non-REPNE valid uop while in LOOP:
  - repne_err=1 and stays set until RST.
